video_word_sched: RTL and testbench

Word-slot scheduler and video timing controller for the DDR serializer path. It runs a free-running 5-cycle phase counter that stays in lockstep with the serializer's load phase. Once per slot it advances horizontal and vertical position counters and presents stable timing (de, hsync, vsync, x, y) for the TMDS encoders. Its outputs hold for one full 10-bit word slot, so the encoder/serializer pair always loads a settled word.

---
 rtl/video_timing_pkg.sv | 28 ++
 rtl/mod_counter.sv | 41 ++++
 rtl/video_word_sched.sv | 138 +++++++++++++
 tb/tb_video_word_sched.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/video_timing_pkg.sv
// Shared types, 640x480@60 defaults and total-size helpers for the video word scheduler.
package video_timing_pkg;

    typedef enum logic {IDLE, RUN} state_t;

    localparam int unsigned DEF_H_ACTIVE = 640;
    localparam int unsigned DEF_H_FP     = 16;
    localparam int unsigned DEF_H_SYNC   = 96;
    localparam int unsigned DEF_H_BP     = 48;
    localparam int unsigned DEF_V_ACTIVE = 480;
    localparam int unsigned DEF_V_FP     = 10;
    localparam int unsigned DEF_V_SYNC   = 2;
    localparam int unsigned DEF_V_BP     = 33;

    localparam int unsigned PHASES    = 5;
    localparam int unsigned MAX_TOTAL = 1024;

    function automatic int unsigned h_total(input int unsigned active, input int unsigned fp,
                                            input int unsigned sync, input int unsigned bp);
        return active + fp + sync + bp;
    endfunction

    function automatic int unsigned v_total(input int unsigned active, input int unsigned fp,
                                            input int unsigned sync, input int unsigned bp);
        return active + fp + sync + bp;
    endfunction

endpackage

// File: rtl/mod_counter.sv
// Modulo-N counter with synchronous clear and enable; exposes its next value and terminal count.
module mod_counter #(
    parameter int unsigned WIDTH   = 10,
    parameter int unsigned MODULUS = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             en_i,
    output logic [WIDTH-1:0] value_o,
    output logic [WIDTH-1:0] next_o,
    output logic             wrap_o
);

    localparam logic [WIDTH-1:0] LAST = WIDTH'(MODULUS - 1);

    logic [WIDTH-1:0] cnt_q, cnt_d;

    assign wrap_o = (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = wrap_o ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign value_o = cnt_q;
    assign next_o  = cnt_d;

endmodule

// File: rtl/video_word_sched.sv
// Word-slot scheduler: 5-phase serializer load counter plus video timing held for a full slot.
module video_word_sched
    import video_timing_pkg::*;
#(
    parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
    parameter int unsigned H_FP     = DEF_H_FP,
    parameter int unsigned H_SYNC   = DEF_H_SYNC,
    parameter int unsigned H_BP     = DEF_H_BP,
    parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
    parameter int unsigned V_FP     = DEF_V_FP,
    parameter int unsigned V_SYNC   = DEF_V_SYNC,
    parameter int unsigned V_BP     = DEF_V_BP,
    parameter logic        SYNC_POL = 1'b0
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       en_i,
    output logic       word_stb_o,
    output logic       frame_start_o,
    output logic       de_o,
    output logic       hsync_o,
    output logic       vsync_o,
    output logic [9:0] x_o,
    output logic [9:0] y_o
);

    localparam int unsigned H_TOTAL = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int unsigned V_TOTAL = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

    if (H_TOTAL > MAX_TOTAL || V_TOTAL > MAX_TOTAL) begin : g_total_check
        $fatal(1, "video_word_sched: H_TOTAL/V_TOTAL must not exceed 1024");
    end

    localparam logic [2:0] PH_LAST = 3'(PHASES - 1);

    // 11-bit bounds so a full 1024-slot line still compares correctly.
    localparam logic [10:0] H_ACT_END = 11'(H_ACTIVE);
    localparam logic [10:0] HS_START  = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] HS_END    = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] V_ACT_END = 11'(V_ACTIVE);
    localparam logic [10:0] VS_START  = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] VS_END    = 11'(V_ACTIVE + V_FP + V_SYNC);

    state_t     state_q;
    logic       word_stb_q, frame_start_q, de_q, hsync_q, vsync_q;

    logic [2:0] unused_phase;
    logic [2:0] phase_nxt;
    logic       ph_last;

    logic [9:0] x_nxt, y_nxt;
    logic       x_wrap, y_wrap;
    logic       advance, slot_clr;
    logic [10:0] x_ext, y_ext;
    logic       frame_start_d, de_d, hs_act, vs_act;

    mod_counter #(
        .WIDTH   (3),
        .MODULUS (PHASES)
    ) u_phase (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clr_i   (1'b0),
        .en_i    (1'b1),
        .value_o (unused_phase),
        .next_o  (phase_nxt),
        .wrap_o  (ph_last)
    );

    // Counters move only at the phase-4 word boundary; any exit from or entry to RUN
    // restarts the raster at (0,0).
    assign advance  = ph_last && en_i && (state_q == RUN);
    assign slot_clr = ph_last && !advance;

    mod_counter #(
        .WIDTH   (10),
        .MODULUS (H_TOTAL)
    ) u_x (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clr_i   (slot_clr),
        .en_i    (advance),
        .value_o (x_o),
        .next_o  (x_nxt),
        .wrap_o  (x_wrap)
    );

    mod_counter #(
        .WIDTH   (10),
        .MODULUS (V_TOTAL)
    ) u_y (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clr_i   (slot_clr),
        .en_i    (advance && x_wrap),
        .value_o (y_o),
        .next_o  (y_nxt),
        .wrap_o  (y_wrap)
    );

    assign x_ext = {1'b0, x_nxt};
    assign y_ext = {1'b0, y_nxt};

    always_comb begin
        frame_start_d = en_i && ((state_q == IDLE) || (x_wrap && y_wrap));
        de_d          = en_i && (x_ext < H_ACT_END) && (y_ext < V_ACT_END);
        hs_act        = en_i && (x_ext >= HS_START) && (x_ext < HS_END);
        vs_act        = en_i && (y_ext >= VS_START) && (y_ext < VS_END);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q       <= IDLE;
            word_stb_q    <= 1'b0;
            frame_start_q <= 1'b0;
            de_q          <= 1'b0;
            hsync_q       <= ~SYNC_POL;
            vsync_q       <= ~SYNC_POL;
        end else begin
            word_stb_q    <= (phase_nxt == PH_LAST);
            frame_start_q <= 1'b0;
            if (ph_last) begin
                state_q       <= en_i ? RUN : IDLE;
                frame_start_q <= frame_start_d;
                de_q          <= de_d;
                hsync_q       <= hs_act ? SYNC_POL : ~SYNC_POL;
                vsync_q       <= vs_act ? SYNC_POL : ~SYNC_POL;
            end
        end
    end

    assign word_stb_o    = word_stb_q;
    assign frame_start_o = frame_start_q;
    assign de_o          = de_q;
    assign hsync_o       = hsync_q;
    assign vsync_o       = vsync_q;

endmodule

// File: tb/tb_video_word_sched.sv
// Scoreboard bench for video_word_sched using a small 8x6 raster.
module tb_video_word_sched;

    localparam int H_A = 4, H_F = 1, H_S = 2, H_B = 1;
    localparam int V_A = 3, V_F = 1, V_S = 1, V_B = 1;
    localparam int H_T = H_A + H_F + H_S + H_B;
    localparam int V_T = V_A + V_F + V_S + V_B;
    localparam int FRAME_CLKS = H_T * V_T * 5;

    typedef struct packed {
        logic       stb;
        logic       fs;
        logic       de;
        logic       hs;
        logic       vs;
        logic [9:0] x;
        logic [9:0] y;
    } obs_t;

    localparam obs_t RESET_VEC = '{stb: 1'b0, fs: 1'b0, de: 1'b0, hs: 1'b1, vs: 1'b1,
                                   x: 10'd0, y: 10'd0};

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en  = 1'b0;
    logic       word_stb, frame_start, de, hsync, vsync;
    logic [9:0] x, y;
    obs_t       obs_now;

    video_word_sched #(
        .H_ACTIVE (H_A), .H_FP (H_F), .H_SYNC (H_S), .H_BP (H_B),
        .V_ACTIVE (V_A), .V_FP (V_F), .V_SYNC (V_S), .V_BP (V_B),
        .SYNC_POL (1'b0)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .en_i          (en),
        .word_stb_o    (word_stb),
        .frame_start_o (frame_start),
        .de_o          (de),
        .hsync_o       (hsync),
        .vsync_o       (vsync),
        .x_o           (x),
        .y_o           (y)
    );

    always #5 clk = ~clk;

    assign obs_now = {word_stb, frame_start, de, hsync, vsync, x, y};

    obs_t exp_q[$];
    int   fs_cycles[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   cyc = 0;
    int   fs_seen = 0;
    int   stb_seen = 0;

    // Slot-level reference model; m_phase is the phase of the current cycle.
    int   m_phase = 0, m_x = 0, m_y = 0;
    bit   m_run = 1'b0, m_fs = 1'b0;

    function automatic obs_t expect_now();
        obs_t e;
        e.stb = (m_phase == 4);
        e.fs  = m_fs;
        e.de  = m_run && (m_x < H_A) && (m_y < V_A);
        e.hs  = !(m_run && (m_x >= H_A + H_F) && (m_x < H_A + H_F + H_S));
        e.vs  = !(m_run && (m_y >= V_A + V_F) && (m_y < V_A + V_F + V_S));
        e.x   = 10'(m_x);
        e.y   = 10'(m_y);
        return e;
    endfunction

    task automatic model_reset();
        m_phase = 0; m_x = 0; m_y = 0; m_run = 1'b0; m_fs = 1'b0;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        vectors++;
        assert (got === want) else begin
            miscompares++;
            $error("FAIL %s: got %0d, want %0d", tag, got, want);
        end
    endtask

    // Advance the model across one edge, push the expectation, then compare after the edge.
    task automatic tick();
        obs_t e;
        if (m_phase == 4) begin
            if (!en) begin
                m_run = 1'b0; m_x = 0; m_y = 0; m_fs = 1'b0;
            end else if (!m_run) begin
                m_run = 1'b1; m_x = 0; m_y = 0; m_fs = 1'b1;
            end else begin
                m_fs = 1'b0;
                if (m_x == H_T - 1) begin
                    m_x = 0;
                    if (m_y == V_T - 1) begin
                        m_y = 0; m_fs = 1'b1;
                    end else begin
                        m_y++;
                    end
                end else begin
                    m_x++;
                end
            end
        end else begin
            m_fs = 1'b0;
        end
        m_phase = (m_phase + 1) % 5;
        exp_q.push_back(expect_now());
        @(posedge clk);
        #1;
        cyc++;
        e = exp_q.pop_front();
        vectors++;
        assert (obs_now === e) else begin
            miscompares++;
            $error("FAIL slot cyc=%0d: got %h, want %h", cyc, obs_now, e);
        end
        if (frame_start) begin
            fs_seen++;
            fs_cycles.push_back(cyc);
        end
        if (word_stb) stb_seen++;
    endtask

    initial begin
        int k;
        int t0;
        bit found;

        // Reset state while held and after release.
        repeat (3) @(posedge clk);
        #1;
        check("reset_held", obs_now, RESET_VEC);
        rst = 1'b0;
        model_reset();
        check("reset_release", obs_now, RESET_VEC);

        // Idle for 40 clocks: strobe every 5th clock, no frame pulse.
        stb_seen = 0; fs_seen = 0;
        repeat (40) tick();
        check("idle_stb_count", stb_seen, 8);
        check("idle_fs_count", fs_seen, 0);

        // Run three frames; first pulse right after the first phase-4 sample.
        fs_cycles.delete();
        fs_seen = 0;
        en = 1'b1;
        t0 = cyc;
        repeat (3 * FRAME_CLKS + 10) tick();
        check("run_fs_count", fs_seen, 4);
        if (fs_cycles.size() == 4) begin
            check("run_first_fs", fs_cycles[0] - t0, 5);
            for (int i = 1; i < 4; i++)
                check("run_fs_period", fs_cycles[i] - fs_cycles[i-1], FRAME_CLKS);
        end

        // Drop en in phase 2 of slot (3,1); slot completes, then raster idles at (0,0).
        found = 1'b0;
        for (int i = 0; i < 2 * FRAME_CLKS && !found; i++) begin
            if (x == 10'd3 && y == 10'd1 && m_phase == 2) found = 1'b1;
            else tick();
        end
        check("reach_x3y1", found, 1);
        en = 1'b0;
        tick();
        tick();
        check("drop_hold_x", x, 3);
        tick();
        check("drop_x", x, 0);
        check("drop_y", y, 0);
        check("drop_de", de, 0);
        check("drop_hsync", hsync, 1);
        check("drop_vsync", vsync, 1);

        // Re-raise at phase 0: pulse appears after the next phase-4 sample.
        fs_seen = 0;
        en = 1'b1;
        repeat (5) tick();
        check("rerun_fs", frame_start, 1);
        check("rerun_fs_count", fs_seen, 1);
        check("rerun_de", de, 1);

        // Return to idle, then pulse en only during phases 0..3.
        en = 1'b0;
        repeat (5) tick();
        fs_seen = 0;
        for (int s = 0; s < 3; s++) begin
            en = 1'b1;
            repeat (4) tick();
            en = 1'b0;
            tick();
        end
        check("pulse_fs_count", fs_seen, 0);
        check("pulse_de", de, 0);

        // Async reset at phase 3 of slot (5,2).
        en = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 2 * FRAME_CLKS && !found; i++) begin
            if (x == 10'd5 && y == 10'd2 && m_phase == 3) found = 1'b1;
            else tick();
        end
        check("reach_x5y2", found, 1);
        check("pre_rst_hsync", hsync, 0);
        #1 rst = 1'b1;
        #1;
        check("rst_async", obs_now, RESET_VEC);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        check("rst_release", obs_now, RESET_VEC);
        k = 0;
        while (!word_stb && k < 10) begin
            tick();
            k++;
        end
        check("rst_stb_clock", k + 1, 5);
        fs_seen = 0;
        repeat (20) tick();
        check("rst_rerun_fs", fs_seen, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
